vid_mem_arbiter: RTL and testbench

//  Shares the single synchronous-read video/system RAM port between the VIC video fetch

---
 rtl/vid_arb_pkg.sv | 30 +++
 rtl/vid_arb_stats.sv | 35 +++
 rtl/vid_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_vid_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_arb_pkg.sv
// ============================================================================
// Module   : vid_arb_pkg
// Purpose  : Shared types and helpers for the video/CPU RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vid_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CAPTURE = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic OWNER_VID = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vid_arb_stats.sv
// ============================================================================
// Module   : vid_arb_stats
// Purpose  : Saturating steal / wait event counters for the RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vid_arb_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        steal_inc,
  input  logic        wait_inc,
  output logic [15:0] stat_steals,
  output logic [15:0] stat_waits
);

  logic [15:0] r_steals;
  logic [15:0] r_waits;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_steals <= 16'd0;
      r_waits  <= 16'd0;
    end else begin
      if (steal_inc && r_steals != 16'hFFFF) r_steals <= r_steals + 16'd1;
      if (wait_inc && r_waits != 16'hFFFF)   r_waits  <= r_waits + 16'd1;
    end
  end

  assign stat_steals = r_steals;
  assign stat_waits  = r_waits;

endmodule

`default_nettype wire

// File: rtl/vid_mem_arbiter.sv
// ============================================================================
// Module   : vid_mem_arbiter
// Purpose  : Shares one sync-read RAM port between video fetch and CPU access.
//            Optional ARB_STATS_EN adds steal/wait statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vid_mem_arbiter
  import vid_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_stale,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_steals,
  output logic [15:0]   stat_waits
`endif
);

  localparam int                  c_WAIT_W     = clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(MAX_WAIT);

  arb_state_t          r_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_ack;
  logic                r_cap_read;
  logic [DW-1:0]       r_rdata;
  logic                r_tag;
  logic                r_prev_vid_req;
  logic [DW-1:0]       r_hold;
  logic                w_cpu_gnt;

  // A pending CPU access takes any free slot, or steals one once it has waited long enough.
  assign w_cpu_gnt = (r_state == PENDING) && (!vid_req || (r_wait_cnt == c_WAIT_LIMIT));

  assign mem_addr  = w_cpu_gnt ? cpu_addr : vid_addr;
  assign mem_we    = w_cpu_gnt & cpu_we;
  assign mem_wdata = cpu_wdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_ack      <= 1'b0;
      r_cap_read <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ack      <= w_cpu_gnt;
      r_cap_read <= w_cpu_gnt & ~cpu_we;
      case (r_state)
        IDLE: begin
          if (cpu_req) r_state <= PENDING;
        end
        PENDING: begin
          if (w_cpu_gnt) begin
            r_state <= CAPTURE;
          end else if (r_wait_cnt != c_WAIT_LIMIT) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
          end
        end
        CAPTURE: begin
          if (r_cap_read) r_rdata <= mem_rdata;
          r_wait_cnt <= '0;
          r_state    <= RELEASE;
        end
        RELEASE: begin
          if (!cpu_req) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_ack   = r_ack;
  assign cpu_rdata = r_cap_read ? mem_rdata : r_rdata;

  // Owner tag follows the read latency so returning data is routed to the right side.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag          <= OWNER_VID;
      r_prev_vid_req <= 1'b0;
      r_hold         <= '0;
    end else begin
      r_tag          <= w_cpu_gnt ? OWNER_CPU : OWNER_VID;
      r_prev_vid_req <= vid_req;
      if (r_tag == OWNER_VID) r_hold <= mem_rdata;
    end
  end

  assign vid_data  = (r_tag == OWNER_CPU) ? r_hold : mem_rdata;
  assign vid_stale = (r_tag == OWNER_CPU) & r_prev_vid_req;

`ifdef ARB_STATS_EN
  logic w_steal_inc;
  logic w_wait_inc;

  assign w_steal_inc = w_cpu_gnt & vid_req;
  assign w_wait_inc  = (r_state == PENDING) & ~w_cpu_gnt;

  vid_arb_stats u_stats (
    .clk         (clk),
    .reset       (reset),
    .steal_inc   (w_steal_inc),
    .wait_inc    (w_wait_inc),
    .stat_steals (stat_steals),
    .stat_waits  (stat_waits)
  );
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_vid_mem_arbiter.sv
// ============================================================================
// Module   : tb_vid_mem_arbiter
// Purpose  : Directed self-checking bench for vid_mem_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vid_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_stale;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_steals;
  logic [15:0] stat_waits;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ram [0:65535];

  vid_mem_arbiter #(.AW(16), .DW(8), .MAX_WAIT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .vid_stale   (vid_stale),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_steals (stat_steals),
    .stat_waits  (stat_waits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM, read-before-write.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i[7:0] ^ i[15:8]);
    ram[16'h1000] = 8'h5A;

    reset = 1'b0; vid_req = 1'b0; vid_addr = 16'h2222;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    step(); step(); step();
    smp();
    check("rst_ack",     32'(cpu_ack),   32'h0);
    check("rst_stale",   32'(vid_stale), 32'h0);
    check("rst_we",      32'(mem_we),    32'h0);
    check("rst_addr",    32'(mem_addr),  32'h2222);
    check("rst_rdata",   32'(cpu_rdata), 32'h0);

    // Test 1: free-slot read
    step(); reset = 1'b1; vid_addr = 16'h0000;
    step(); cpu_req = 1'b1; cpu_addr = 16'h1000;
    smp();  check("t1_c0_addr", 32'(mem_addr), 32'h0000);
    step(); smp();
    check("t1_c1_addr", 32'(mem_addr), 32'h1000);
    check("t1_c1_ack",  32'(cpu_ack),  32'h0);
    step(); smp();
    check("t1_c2_ack",   32'(cpu_ack),   32'h1);
    check("t1_c2_rdata", 32'(cpu_rdata), 32'h5A);
    check("t1_c2_stale", 32'(vid_stale), 32'h0);
    step(); cpu_req = 1'b0; smp();
    check("t1_c3_ack",   32'(cpu_ack),   32'h0);
    check("t1_c3_rdata", 32'(cpu_rdata), 32'h5A);
    step();

    // Test 2: video priority for 5 cycles, then a free slot
    for (int k = 0; k <= 7; k++) begin
      step();
      vid_addr = 16'h3000 + 16'(k);
      vid_req  = (k <= 4);
      if (k == 0) begin cpu_req = 1'b1; cpu_addr = 16'h1001; end
      if (k == 7) cpu_req = 1'b0;
      smp();
      check("t2_stale", 32'(vid_stale), 32'h0);
      if (k <= 4) check("t2_vid_addr", 32'(mem_addr), 32'(vid_addr));
      if (k <= 5 && k >= 1) check("t2_no_ack", 32'(cpu_ack), 32'h0);
      if (k == 1) check("t2_vdata_b1", 32'(vid_data), 32'h30);
      if (k == 5) begin
        check("t2_gnt_addr", 32'(mem_addr), 32'h1001);
        check("t2_vdata_b5", 32'(vid_data), 32'h34);
      end
      if (k == 6) begin
        check("t2_ack",      32'(cpu_ack),   32'h1);
        check("t2_rdata",    32'(cpu_rdata), 32'h11);
        check("t2_vdata_b6", 32'(vid_data),  32'h34);
      end
    end

    // Test 3: video never releases; the 16th PENDING cycle steals a slot
    for (int k = 0; k <= 18; k++) begin
      step();
      vid_req  = 1'b1;
      vid_addr = 16'h4000 + 16'(k);
      if (k == 0) begin cpu_req = 1'b1; cpu_addr = 16'h1002; end
      if (k == 18) cpu_req = 1'b0;
      smp();
      if (k >= 1 && k <= 15) begin
        check("t3_wait_addr", 32'(mem_addr), 32'(vid_addr));
        check("t3_wait_ack",  32'(cpu_ack),  32'h0);
      end
      if (k == 16) begin
        check("t3_steal_addr", 32'(mem_addr),  32'h1002);
        check("t3_pre_vdata",  32'(vid_data),  32'h4F);
        check("t3_pre_stale",  32'(vid_stale), 32'h0);
      end
      if (k == 17) begin
        check("t3_ack",    32'(cpu_ack),   32'h1);
        check("t3_rdata",  32'(cpu_rdata), 32'h12);
        check("t3_stale",  32'(vid_stale), 32'h1);
        check("t3_vdata",  32'(vid_data),  32'h4F);
      end
      if (k == 18) begin
        check("t3_post_stale", 32'(vid_stale), 32'h0);
        check("t3_post_vdata", 32'(vid_data),  32'h51);
      end
    end
`ifdef ARB_STATS_EN
    check("t3_stat_steals", 32'(stat_steals), 32'd1);
    check("t3_stat_waits",  32'(stat_waits),  32'd19);
`endif

    // Test 4: write in a free slot, then video reads it back
    step(); vid_req = 1'b0; vid_addr = 16'h0000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h9400; cpu_wdata = 8'h07;
    smp();  check("t4_d0_we", 32'(mem_we), 32'h0);
    step(); smp();
    check("t4_d1_we",    32'(mem_we),    32'h1);
    check("t4_d1_addr",  32'(mem_addr),  32'h9400);
    check("t4_d1_wdata", 32'(mem_wdata), 32'h07);
    step(); smp();
    check("t4_d2_we",    32'(mem_we),    32'h0);
    check("t4_d2_ack",   32'(cpu_ack),   32'h1);
    check("t4_d2_rdata", 32'(cpu_rdata), 32'h12);
    step(); cpu_req = 1'b0; smp();
    check("t4_d3_we", 32'(mem_we), 32'h0);
    step(); cpu_we = 1'b0; vid_req = 1'b1; vid_addr = 16'h9400;
    step(); vid_req = 1'b0; smp();
    check("t4_vid_read", 32'(vid_data), 32'h07);

    // Test 5: request held high after ack is not re-issued
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h9401; cpu_wdata = 8'h33;
    step(); smp(); check("t5_e1_we", 32'(mem_we), 32'h1);
    step(); smp();
    check("t5_e2_ack",   32'(cpu_ack),   32'h1);
    check("t5_e2_rdata", 32'(cpu_rdata), 32'h12);
    for (int k = 0; k < 4; k++) begin
      step(); smp();
      check("t5_held_ack",  32'(cpu_ack),  32'h0);
      check("t5_held_we",   32'(mem_we),   32'h0);
      check("t5_held_addr", 32'(mem_addr), 32'(vid_addr));
    end
    step(); cpu_req = 1'b0;
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h9401;
    step(); smp(); check("t5_new_addr", 32'(mem_addr), 32'h9401);
    step(); smp();
    check("t5_new_ack",   32'(cpu_ack),   32'h1);
    check("t5_new_rdata", 32'(cpu_rdata), 32'h33);
    step(); cpu_req = 1'b0;

    // Test 6: reset on the edge that would enter CAPTURE
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1004;
    step(); reset = 1'b0; smp();
    check("t6_gnt_addr", 32'(mem_addr), 32'h1004);
    step(); reset = 1'b1; cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 16'h5005; smp();
    check("t6_no_ack",  32'(cpu_ack),   32'h0);
    check("t6_rdata",   32'(cpu_rdata), 32'h0);
    check("t6_vdata",   32'(vid_data),  32'h14);
    check("t6_stale",   32'(vid_stale), 32'h0);
`ifdef ARB_STATS_EN
    check("t6_stat_steals", 32'(stat_steals), 32'd0);
    check("t6_stat_waits",  32'(stat_waits),  32'd0);
`endif
    step(); vid_req = 1'b0; smp();
    check("t6_no_ack2", 32'(cpu_ack),  32'h0);
    check("t6_vdata2",  32'(vid_data), 32'h55);
    check("t6_idle",    32'(mem_addr), 32'h5005);
    step(); cpu_req = 1'b1;
    step(); step(); smp();
    check("t6_retry_ack",   32'(cpu_ack),   32'h1);
    check("t6_retry_rdata", 32'(cpu_rdata), 32'h14);
    step(); cpu_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
